// File: rtl/bytecode_pkg.sv
// Shared encoding for the bytecode writer and the core's decoder: opcode bytes,
// instruction kinds, instruction lengths and the writer FSM state type.
package bytecode_pkg;

  localparam logic [7:0] OPC_ALU2 = 8'h02;
  localparam logic [7:0] OPC_ALU1 = 8'h01;
  localparam logic [7:0] OPC_HALT = 8'hFF;

  typedef enum logic [1:0] {
    KIND_ALU2    = 2'd0,
    KIND_ALU1    = 2'd1,
    KIND_HALT    = 2'd2,
    KIND_ILLEGAL = 2'd3
  } kind_e;

  localparam logic [2:0] LEN_ALU2 = 3'd4;
  localparam logic [2:0] LEN_ALU1 = 3'd3;
  localparam logic [2:0] LEN_HALT = 3'd1;

  typedef enum logic [2:0] {
    StIdle,
    StB0,
    StB1,
    StB2,
    StB3,
    StHalted,
    StError
  } state_e;

  // Illegal kinds report zero length; they are rejected before length matters.
  function automatic logic [2:0] instr_len(kind_e kind);
    case (kind)
      KIND_ALU2: instr_len = LEN_ALU2;
      KIND_ALU1: instr_len = LEN_ALU1;
      KIND_HALT: instr_len = LEN_HALT;
      default:   instr_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/bytecode_writer.sv
// Serialises ALU2/ALU1/HALT instructions into program memory, one byte per cycle.
// Optional running XOR checksum output enabled by BYTECODE_WRITER_CHECKSUM_EN.
module bytecode_writer
  import bytecode_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_kind,
  input  logic [5:0]        instr_op,
  input  logic [7:0]        instr_a,
  input  logic [7:0]        instr_b,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W:0]   wr_ptr,
  output logic              done,
  output logic              err
`ifdef BYTECODE_WRITER_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  localparam logic [ADDR_W+1:0] DepthW = (ADDR_W + 2)'(DEPTH);

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d, kind_in;
  logic [5:0]        op_q, op_d;
  logic [7:0]        a_q, a_d, b_q, b_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d, byte_sel;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;
  logic [ADDR_W+1:0] end_ptr;

  assign kind_in = kind_e'(instr_kind);
  // ready_q is only ever high in IDLE, so it doubles as the state qualifier.
  assign accept  = instr_valid & ready_q & ~clear;
  assign end_ptr = {1'b0, wr_ptr_q} + {{(ADDR_W - 1){1'b0}}, instr_len(kind_in)};

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, we_q};
    done_d   = done_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          kind_d = kind_in;
          op_d   = instr_op;
          a_d    = instr_a;
          b_d    = instr_b;
          if (kind_in == KIND_ILLEGAL || end_ptr > DepthW) begin
            state_d = StError;
            err_d   = 1'b1;
          end else begin
            state_d = StB0;
          end
        end
      end
      StB0: begin
        if (kind_q == KIND_HALT) begin
          state_d = StHalted;
          done_d  = 1'b1;
        end else begin
          state_d = StB1;
        end
      end
      StB1:     state_d = StB2;
      StB2:     state_d = (kind_q == KIND_ALU2) ? StB3 : StIdle;
      StB3:     state_d = StIdle;
      StHalted: state_d = StHalted;
      StError:  state_d = StError;
      default:  state_d = StIdle;
    endcase
    if (clear) begin
      state_d  = StIdle;
      wr_ptr_d = '0;
      done_d   = 1'b0;
      err_d    = 1'b0;
    end
  end

  // Byte for the state being entered, so the write appears in that state's cycle.
  always_comb begin
    byte_sel = wdata_q;
    unique case (state_d)
      StB0: begin
        case (kind_d)
          KIND_ALU2: byte_sel = OPC_ALU2;
          KIND_ALU1: byte_sel = OPC_ALU1;
          default:   byte_sel = OPC_HALT;
        endcase
      end
      StB1:    byte_sel = {2'b00, op_d};
      StB2:    byte_sel = a_d;
      StB3:    byte_sel = b_d;
      default: byte_sel = wdata_q;
    endcase
  end

  always_comb begin
    we_d    = (state_d == StB0) || (state_d == StB1) || (state_d == StB2) || (state_d == StB3);
    ready_d = (state_d == StIdle);
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (we_d) begin
      addr_d  = wr_ptr_d[ADDR_W-1:0];
      wdata_d = byte_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      kind_q   <= KIND_ALU2;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      wr_ptr_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wr_ptr_q <= wr_ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign instr_ready = ready_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign wr_ptr      = wr_ptr_q;
  assign done        = done_q;
  assign err         = err_q;

`ifdef BYTECODE_WRITER_CHECKSUM_EN
  logic [7:0] chk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q <= '0;
    end else if (clear) begin
      chk_q <= '0;
    end else if (we_q) begin
      chk_q <= chk_q ^ wdata_q;
    end
  end

  assign checksum = chk_q;
`endif

endmodule

// File: tb/tb_bytecode_writer.sv
// Directed bench for bytecode_writer: table of instructions plus corner sequences.
module tb_bytecode_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [1:0]  instr_kind = 2'd0;
  logic [5:0]  instr_op = 6'd0;
  logic [7:0]  instr_a = 8'd0;
  logic [7:0]  instr_b = 8'd0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [10:0] wr_ptr;
  logic        done;
  logic        err;
`ifdef BYTECODE_WRITER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] mem_model [1024];

  bytecode_writer #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_kind  (instr_kind),
    .instr_op    (instr_op),
    .instr_a     (instr_a),
    .instr_b     (instr_b),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .wr_ptr      (wr_ptr),
    .done        (done),
    .err         (err)
`ifdef BYTECODE_WRITER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem_model[mem_addr] <= mem_wdata;

  typedef struct {
    logic [1:0]  kind;
    logic [5:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    int          len;
    logic [31:0] bytes;
    int          base;
    logic        ready_after;
    logic        done_after;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", {31'd0, instr_ready}, 32'd1);
  endtask

  task automatic issue(input logic [1:0] k, input logic [5:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    wait_ready();
    instr_kind  = k;
    instr_op    = op;
    instr_a     = a;
    instr_b     = b;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic expect_bytes(input int base, input int n, input logic [31:0] bytes);
    for (int i = 0; i < n; i++) begin
      chk("wr_we", {31'd0, mem_we}, 32'd1);
      chk("wr_addr", {22'd0, mem_addr}, base + i);
      chk("wr_data", {24'd0, mem_wdata}, {24'd0, bytes[31-8*i -: 8]});
      chk("wr_busy", {31'd0, instr_ready}, 32'd0);
      tick();
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic fill(input int n_alu2, input int n_alu1);
    for (int i = 0; i < n_alu2; i++) issue(2'd0, 6'd1, 8'd2, 8'd3);
    for (int i = 0; i < n_alu1; i++) issue(2'd1, 6'd4, 8'd5, 8'd0);
    wait_ready();
  endtask

  initial begin
    vecs[0] = '{2'd0, 6'h05, 8'h12, 8'h34, 4, 32'h02051234, 0, 1'b1, 1'b0};
    vecs[1] = '{2'd1, 6'h3F, 8'hAA, 8'h00, 3, 32'h013FAA00, 4, 1'b1, 1'b0};
    vecs[2] = '{2'd0, 6'h2A, 8'h00, 8'hFF, 4, 32'h022A00FF, 7, 1'b1, 1'b0};
    vecs[3] = '{2'd1, 6'h00, 8'h7E, 8'h00, 3, 32'h01007E00, 11, 1'b1, 1'b0};
    vecs[4] = '{2'd2, 6'h00, 8'h00, 8'h00, 1, 32'hFF000000, 14, 1'b0, 1'b1};

    // Reset values while rst is held
    tick();
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_ptr", {21'd0, wr_ptr}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", {31'd0, instr_ready}, 32'd1);

    // Table of back-to-back instructions ending in HALT
    foreach (vecs[i]) begin
      issue(vecs[i].kind, vecs[i].op, vecs[i].a, vecs[i].b);
      expect_bytes(vecs[i].base, vecs[i].len, vecs[i].bytes);
      chk("tbl_ready", {31'd0, instr_ready}, {31'd0, vecs[i].ready_after});
      chk("tbl_ptr", {21'd0, wr_ptr}, vecs[i].base + vecs[i].len);
      chk("tbl_done", {31'd0, done}, {31'd0, vecs[i].done_after});
      chk("tbl_we_idle", {31'd0, mem_we}, 32'd0);
    end
    tick();
    chk("halt_stays", {31'd0, instr_ready}, 32'd0);
    chk("mem_0", {24'd0, mem_model[0]}, 32'h02);
    chk("mem_13", {24'd0, mem_model[13]}, 32'h7E);

    // Clear then ALU1 + HALT
    do_clear();
    chk("clr_done", {31'd0, done}, 32'd0);
    chk("clr_ptr", {21'd0, wr_ptr}, 32'd0);
    issue(2'd1, 6'h3F, 8'hAA, 8'h00);
    expect_bytes(0, 3, 32'h013FAA00);
    issue(2'd2, 6'h00, 8'h00, 8'h00);
    expect_bytes(3, 1, 32'hFF000000);
    chk("ah_done", {31'd0, done}, 32'd1);
    chk("ah_ready", {31'd0, instr_ready}, 32'd0);
    chk("ah_mem3", {24'd0, mem_model[3]}, 32'hFF);
`ifdef BYTECODE_WRITER_CHECKSUM_EN
    chk("checksum", {24'd0, checksum}, 32'h6B);
`endif

    // Overflow: ALU2 at wr_ptr 1021
    do_clear();
    fill(253, 3);
    chk("fill_1021", {21'd0, wr_ptr}, 32'd1021);
    issue(2'd0, 6'h01, 8'h01, 8'h01);
    chk("ovf_err", {31'd0, err}, 32'd1);
    chk("ovf_we", {31'd0, mem_we}, 32'd0);
    chk("ovf_ready", {31'd0, instr_ready}, 32'd0);
    tick();
    chk("ovf_we2", {31'd0, mem_we}, 32'd0);
    chk("ovf_ptr", {21'd0, wr_ptr}, 32'd1021);
    do_clear();
    issue(2'd2, 6'h00, 8'h00, 8'h00);
    expect_bytes(0, 1, 32'hFF000000);
    chk("ovf_halt_done", {31'd0, done}, 32'd1);

    // ALU1 at wr_ptr 1022 does not fit
    do_clear();
    fill(254, 2);
    chk("fill_1022", {21'd0, wr_ptr}, 32'd1022);
    issue(2'd1, 6'h01, 8'h01, 8'h00);
    chk("alu1_1022_err", {31'd0, err}, 32'd1);
    chk("alu1_1022_we", {31'd0, mem_we}, 32'd0);

    // HALT at wr_ptr 1023 fits exactly
    do_clear();
    fill(255, 1);
    chk("fill_1023", {21'd0, wr_ptr}, 32'd1023);
    issue(2'd2, 6'h00, 8'h00, 8'h00);
    expect_bytes(1023, 1, 32'hFF000000);
    chk("edge_ptr", {21'd0, wr_ptr}, 32'd1024);
    chk("edge_done", {31'd0, done}, 32'd1);
    chk("edge_err", {31'd0, err}, 32'd0);

    // Illegal kind
    do_clear();
    issue(2'd3, 6'h00, 8'h00, 8'h00);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_we", {31'd0, mem_we}, 32'd0);
    chk("ill_ready", {31'd0, instr_ready}, 32'd0);
    tick();
    chk("ill_hold", {31'd0, instr_ready}, 32'd0);
    do_clear();
    chk("ill_clr_err", {31'd0, err}, 32'd0);
    chk("ill_clr_ptr", {21'd0, wr_ptr}, 32'd0);
    chk("ill_clr_ready", {31'd0, instr_ready}, 32'd1);

    // Asynchronous reset during B2 of an ALU2
    issue(2'd1, 6'h01, 8'h02, 8'h00);
    expect_bytes(0, 3, 32'h01010200);
    issue(2'd0, 6'h11, 8'h22, 8'h33);
    tick();
    tick();
    chk("b2_we", {31'd0, mem_we}, 32'd1);
    chk("b2_addr", {22'd0, mem_addr}, 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", {31'd0, mem_we}, 32'd0);
    chk("arst_addr", {22'd0, mem_addr}, 32'd0);
    chk("arst_ptr", {21'd0, wr_ptr}, 32'd0);
    chk("arst_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    issue(2'd1, 6'h07, 8'h08, 8'h00);
    expect_bytes(0, 3, 32'h01070800);

    // clear and instr_valid together: not accepted, taken next cycle
    chk("pre_cv_ptr", {21'd0, wr_ptr}, 32'd3);
    instr_kind  = 2'd0;
    instr_op    = 6'h03;
    instr_a     = 8'h04;
    instr_b     = 8'h05;
    instr_valid = 1'b1;
    clear       = 1'b1;
    tick();
    clear = 1'b0;
    chk("cv_we", {31'd0, mem_we}, 32'd0);
    chk("cv_ptr", {21'd0, wr_ptr}, 32'd0);
    chk("cv_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
    expect_bytes(0, 4, 32'h02030405);
    chk("cv_ptr_end", {21'd0, wr_ptr}, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/bytecode_writer.md
Name: bytecode_writer

Overview:
- Encoder counterpart to the bytecode-executing microprocessor core.
- Accepts one instruction per valid/ready handshake and serialises it into the 1024x8 program memory the core executes from, one byte per cycle, starting at address 0.
- Emits the exact byte layout the core decodes: ALU2 = 0x02,op,a,b; ALU1 = 0x01,op,a; HALT = 0xFF.
- Sits between a host/loader and the program memory write port; asserts done once HALT is written so the core's enable can be raised.

Parameters:
DEPTH, 1024, program memory size in bytes
ADDR_W, 10, memory address width; must equal clog2(DEPTH)

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous restart: pointer to 0, done/err cleared, FSM to IDLE
instr_valid  input  1  host presents an instruction
instr_ready  output  1  writer can accept; high only in IDLE
instr_kind  input  2  0=ALU2, 1=ALU1, 2=HALT, 3=illegal
instr_op  input  6  ALU operation select
instr_a  input  8  first operand
instr_b  input  8  second operand (ALU2 only)
mem_we  output  1  byte write strobe
mem_addr  output  ADDR_W  write address
mem_wdata  output  8  write data
wr_ptr  output  ADDR_W+1  bytes written so far (0..DEPTH)
done  output  1  sticky; HALT byte written
err  output  1  sticky; overflow or illegal kind

Behaviour:
- Clock/reset are fixed: one clock, clk; reset is asynchronous and active-high, rst.
- Reset values: instr_ready=0 in the reset cycle, 1 from the first clock after deassertion. mem_we=0, mem_addr=0, mem_wdata=0, wr_ptr=0, done=0, err=0. FSM enters IDLE.
- FSM states: IDLE, B0 (opcode), B1 (op), B2 (a), B3 (b), HALTED, ERROR.
- IDLE: instr_ready=1. On instr_valid & instr_ready, latch all instr_* fields and compute len (ALU2=4, ALU1=3, HALT=1).
  - If kind==3, or wr_ptr+len > DEPTH: go to ERROR, set err=1, write nothing.
  - Otherwise go to B0.
- Byte emission, one byte per cycle with mem_we=1, mem_addr=wr_ptr, and wr_ptr incremented on the same edge:
  - B0 writes the opcode byte 0x02, 0x01 or 0xFF.
  - B1 writes {2'b00, op}.
  - B2 writes a.
  - B3 writes b.
- Transitions after each byte:
  - ALU2: B0→B1→B2→B3→IDLE.
  - ALU1: B0→B1→B2→IDLE.
  - HALT: B0→HALTED, with done=1 from the cycle after the 0xFF write.
- Latency and throughput: handshake in cycle N → first write in cycle N+1 → last write in cycle N+len → instr_ready high in cycle N+len+1. Throughput is len+1 cycles per instruction.
- mem_we is 0 in IDLE, HALTED and ERROR. mem_addr and mem_wdata hold their last values when not writing.
- HALTED and ERROR: instr_ready=0; only clear or rst leaves these states.
- clear has priority over everything except rst.
  - Mid-instruction clear abandons the remaining bytes; bytes already written are left in memory.
  - clear and instr_valid in the same cycle: the instruction is not accepted.
- Boundary cases:
  - wr_ptr==DEPTH-1 with HALT pending: accepted (fits exactly); wr_ptr ends at DEPTH.
  - wr_ptr==DEPTH-2 with ALU1 pending: ERROR.
- rst mid-instruction: immediate return to reset values; memory contents are not the writer's concern.

Optional Feature:
- Macro: BYTECODE_WRITER_CHECKSUM_EN.
- When defined:
  - Adds output checksum [7:0], a running XOR of every byte written.
  - Reset and clear set it to 0; it updates on the same edge as each mem_we write.
  - Value is final once done=1.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package bytecode_pkg holds:
  - opcode constants: OPC_ALU2=8'h02, OPC_ALU1=8'h01, OPC_HALT=8'hFF;
  - kind enum: KIND_ALU2, KIND_ALU1, KIND_HALT, KIND_ILLEGAL;
  - instruction length constants (4, 3, 1);
  - FSM state typedef.
- The microprocessor decoder imports the same opcode constants.
- No sub-module: FSM plus a byte mux. Checksum is inline logic.

Test Plan:
- Reset then ALU2 op=6'h05 a=0x12 b=0x34 → writes 0x02,0x05,0x12,0x34 at addr 0..3 in 4 consecutive cycles; wr_ptr=4; instr_ready back 5 cycles after handshake.
- ALU1 op=6'h3F a=0xAA then HALT → writes 0x01,0x3F,0xAA,0xFF at 0..3; done=1; instr_ready stays 0. With CHECKSUM_EN, checksum=0x01^0x3F^0xAA^0xFF=0x6B.
- Fill to wr_ptr=1021, then issue ALU2 → err=1, no mem_we, wr_ptr stays 1021. Then HALT after clear is written at addr 0.
- instr_kind=3 → err=1, no write, instr_ready=0; clear → IDLE, err=0, wr_ptr=0.
- Assert rst asynchronously during B2 of an ALU2 → outputs reset immediately with no edge needed; mem_we=0; next instruction writes at addr 0.
- clear asserted in the same cycle as instr_valid in IDLE → instruction not accepted; the following cycle accepts it and writes at addr 0.
